// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: control-bundle bit
// positions, default bundle widths and the occupancy type.
package pipe_pkg;

    // Control bundle layout as packed by the decode stage.
    localparam int CTRL_MEMTOREG_LSB = 0;
    localparam int CTRL_MEMTOREG_W   = 2;
    localparam int CTRL_REGWRITE     = 2;
    localparam int CTRL_MEMREAD      = 3;
    localparam int CTRL_MEMWRITE     = 4;

    // Default bundle widths for a typical boundary.
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_RD_W   = 5;

    // Number of entries held by a stage (0..2).
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid flag plus control, destination
// and payload. Clearing drops the entry and zeroes control/destination so a
// bubble never looks like a real instruction; the payload keeps its value.
module pipe_slot #(
    parameter int CTRL_W = 8,
    parameter int RD_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [RD_W-1:0]   d_rd,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [RD_W-1:0]   rd,
    output logic [DATA_W-1:0] data
);

    // Slot register: clear has priority over load so a flush always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            rd    <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
            rd    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            rd    <= d_rd;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN to add a second (skid) slot, which makes in_ready
// a pure register output while keeping one beat per cycle throughput.
// Without it, a single slot is used and in_ready = !out_valid || out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RD_W   = DEF_RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output occ_t              occupancy
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [RD_W-1:0]   m_rd;
    logic [DATA_W-1:0] m_data;
    logic              m_load;
    logic              m_clr;
    logic [CTRL_W-1:0] m_d_ctrl;
    logic [RD_W-1:0]   m_d_rd;
    logic [DATA_W-1:0] m_d_data;
    logic              m_pop;
    logic              push;

    assign m_pop = m_valid & out_ready;
    assign push  = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [RD_W-1:0]   s_rd;
    logic [DATA_W-1:0] s_data;
    logic              s_load;
    logic              s_clr;
    logic              m_from_s;

    // S is a flop, so in_ready has no combinational path from out_ready.
    assign in_ready  = ~s_valid;
    assign occupancy = occ_t'({1'b0, m_valid}) + occ_t'({1'b0, s_valid});

    // Slot steering: S refills M on a pop; new beats go to M when it is free
    // or draining, otherwise they land in S.
    always_comb begin
        m_load   = 1'b0;
        m_clr    = 1'b0;
        s_load   = 1'b0;
        s_clr    = 1'b0;
        m_from_s = 1'b0;
        if (flush) begin
            m_clr = 1'b1;
            s_clr = 1'b1;
        end else if (m_pop && s_valid) begin
            // in_ready is low while S is full, so no push can coincide here.
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clr    = 1'b1;
        end else if (push && (!m_valid || m_pop)) begin
            m_load = 1'b1;
        end else if (push) begin
            s_load = 1'b1;
        end else if (m_pop) begin
            m_clr = 1'b1;
        end
    end

    // Source for M: the skid entry when it is draining, else the input.
    always_comb begin
        m_d_ctrl = in_ctrl;
        m_d_rd   = in_rd;
        m_d_data = in_data;
        if (m_from_s) begin
            m_d_ctrl = s_ctrl;
            m_d_rd   = s_rd;
            m_d_data = s_data;
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .RD_W   (RD_W),
        .DATA_W (DATA_W)
    ) u_slot_s (
        .clk    (clk),
        .rst    (rst),
        .clr    (s_clr),
        .load   (s_load),
        .d_ctrl (in_ctrl),
        .d_rd   (in_rd),
        .d_data (in_data),
        .valid  (s_valid),
        .ctrl   (s_ctrl),
        .rd     (s_rd),
        .data   (s_data)
    );
`else
    assign in_ready  = ~m_valid | out_ready;
    assign occupancy = occ_t'({1'b0, m_valid});

    // Single slot: load on any accepted beat, drop on a pop with no refill.
    always_comb begin
        m_load = 1'b0;
        m_clr  = 1'b0;
        if (flush) begin
            m_clr = 1'b1;
        end else if (push) begin
            m_load = 1'b1;
        end else if (m_pop) begin
            m_clr = 1'b1;
        end
    end

    // M is always fed straight from the input.
    always_comb begin
        m_d_ctrl = in_ctrl;
        m_d_rd   = in_rd;
        m_d_data = in_data;
    end
`endif

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .RD_W   (RD_W),
        .DATA_W (DATA_W)
    ) u_slot_m (
        .clk    (clk),
        .rst    (rst),
        .clr    (m_clr),
        .load   (m_load),
        .d_ctrl (m_d_ctrl),
        .d_rd   (m_d_rd),
        .d_data (m_d_data),
        .valid  (m_valid),
        .ctrl   (m_ctrl),
        .rd     (m_rd),
        .data   (m_data)
    );

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_rd    = m_rd;
    assign out_data  = m_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed stimulus with a scoreboard
// queue of accepted beats, drained and compared by an independent monitor.
// Works with or without PIPE_STAGE_SKID_EN defined.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int RD_W   = 5;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [RD_W-1:0]   in_rd = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_data;
    occ_t              occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [RD_W-1:0]   r;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t q[$];
    beat_t mon_b;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .RD_W   (RD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c, input logic [4:0] r);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
        in_rd    = r;
    endtask

    // Any reset empties the stage, so the expected contents go with it.
    always @(posedge rst) q.delete();

    // Monitor: evaluates the handshakes that will happen on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                q.delete();
            end else begin
                if (!out_valid) begin
                    chk("bubble_ctrl_rd", {19'd0, out_rd, out_ctrl}, 32'd0);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected actual=0x%0h required=none", out_data);
                    end else begin
                        mon_b = q.pop_front();
                        $display("pop data=0x%0h ctrl=0x%0h rd=%0d", out_data, out_ctrl, out_rd);
                        chk("pop_data", out_data, mon_b.d);
                        chk("pop_ctrl", {24'd0, out_ctrl}, {24'd0, mon_b.c});
                        chk("pop_rd", {27'd0, out_rd}, {27'd0, mon_b.r});
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back('{c: in_ctrl, r: in_rd, d: in_data});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a live input present.
        drive(1'b1, 32'hDEADBEEF, 8'hAA, 5'd9);
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ctrl", {24'd0, out_ctrl}, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 32'hDEADBEEF, 8'hAA, 5'd9);
        rst = 1'b0;
        step();
        chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

        // Streaming: one beat per cycle, each visible one cycle after its push.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, i[7:0], i[4:0]);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            step();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_data", out_data, i);
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
        end
        drive(1'b0, 32'd0, 8'd0, 5'd0);
        step();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Stall with downstream blocked.
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 8'h01, 5'd1);
        step();
        chk("stall_occ1", {30'd0, occupancy}, 32'd1);
        drive(1'b1, 32'h11, 8'h02, 5'd2);
        chk("stall_ready1", {31'd0, in_ready}, SKID ? 32'd1 : 32'd0);
        step();
        chk("stall_occ2", {30'd0, occupancy}, SKID ? 32'd2 : 32'd1);
        chk("stall_ready_full", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h12, 8'h03, 5'd3);
        step();
        chk("stall_occ_hold", {30'd0, occupancy}, SKID ? 32'd2 : 32'd1);
        chk("stall_head", out_data, 32'h10);
        drive(1'b0, 32'd0, 8'd0, 5'd0);
        out_ready = 1'b1;
        step();
        chk("stall_second_valid", {31'd0, out_valid}, SKID ? 32'd1 : 32'd0);
        if (SKID) chk("stall_second_data", out_data, 32'h11);
        step();
        chk("stall_drained", {31'd0, out_valid}, 32'd0);

        // Flush while full, with a beat offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 8'h05, 5'd3);
        step();
        drive(1'b1, 32'h21, 8'h06, 5'd4);
        step();
        chk("flush_pre_occ", {30'd0, occupancy}, SKID ? 32'd2 : 32'd1);
        flush = 1'b1;
        drive(1'b1, 32'h99, 8'h07, 5'd5);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 8'd0, 5'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ctrl", {24'd0, out_ctrl}, 32'd0);
        chk("flush_rd", {27'd0, out_rd}, 32'd0);
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        step();
        chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

        // Bubble after a pop zeroes control and destination, payload holds.
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 8'hFF, 5'd7);
        step();
        drive(1'b0, 32'd0, 8'd0, 5'd0);
        chk("bubble_pre_ctrl", {24'd0, out_ctrl}, 32'hFF);
        chk("bubble_pre_rd", {27'd0, out_rd}, 32'd7);
        out_ready = 1'b1;
        step();
        chk("bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
        chk("bubble_rd", {27'd0, out_rd}, 32'd0);
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_data_hold", out_data, 32'h55);

        // Asynchronous reset between edges while stalled.
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 8'h11, 5'd6);
        step();
        drive(1'b1, 32'h31, 8'h12, 5'd8);
        step();
        drive(1'b0, 32'd0, 8'd0, 5'd0);
        chk("arst_pre_occ", {30'd0, occupancy}, SKID ? 32'd2 : 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_occ", {30'd0, occupancy}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_ctrl", {24'd0, out_ctrl}, 32'd0);
        rst = 1'b0;
        drive(1'b1, 32'h40, 8'h21, 5'd10);
        step();
        drive(1'b0, 32'd0, 8'd0, 5'd0);
        chk("arst_first_push_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_first_push_data", out_data, 32'h40);
        out_ready = 1'b1;
        step();
        chk("arst_drained", {31'd0, out_valid}, 32'd0);
        step();
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
